// File: rtl/mul_writeback.sv
// Writeback stage after the multiplier: buffers products in a small FIFO,
// shares the register-file write port with the ALU and flags pending writes.
module mul_writeback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mul_valid,
    output logic                   mul_ready,
    input  logic [DATA_W-1:0]      mul_rd,
    input  logic [DATA_W-1:0]      m_co,
    input  logic [ADDR_W-1:0]      mul_rd_addr,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [DATA_W-1:0]      alu_rd,
    input  logic [ADDR_W-1:0]      alu_rd_addr,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   hi_we,
    output logic [DATA_W-1:0]      hi_wdata,
    output logic [2**ADDR_W-1:0]   pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] co;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   off;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_cnt;
    logic            full;
    logic            empty;
    logic            push;
    logic            mul_gnt;
    logic            alu_gnt;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mul_ready = !full;
    assign push      = mul_valid && !full;
    assign head      = mem[rd_ptr];

    // Full or a starved head overrides a waiting ALU result.
    assign mul_gnt = !empty &&
                     (!alu_valid || full || starve_cnt == SW'(STARVE_MAX));
    assign alu_gnt   = alu_valid && !mul_gnt;
    assign alu_ready = alu_gnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: mul_rd, co: m_co, addr: mul_rd_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            hi_we      <= 1'b0;
            hi_wdata   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (mul_gnt) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(mul_gnt);

            if (empty || mul_gnt) begin
                starve_cnt <= '0;
            end else if (alu_gnt && starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            unique case (1'b1)
                mul_gnt: begin
                    rf_we    <= (head.addr != '0);
                    rf_waddr <= head.addr;
                    rf_wdata <= head.rd;
                    hi_we    <= 1'b1;
                    hi_wdata <= head.co;
                end
                alu_gnt: begin
                    rf_we    <= (alu_rd_addr != '0);
                    rf_waddr <= alu_rd_addr;
                    rf_wdata <= alu_rd;
                    hi_we    <= 1'b0;
                end
                default: begin
                    rf_we <= 1'b0;
                    hi_we <= 1'b0;
                end
            endcase
        end
    end

    // Slot i is live when its distance from the head is below count.
    always_comb begin
        pending_mask = '0;
        off          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) pending_mask[mem[i].addr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_mul_writeback.sv
// Randomised and directed bench for mul_writeback against a queue-based
// model of the writeback arbitration.
module tb_mul_writeback;

    localparam int D  = 2;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_valid;
    logic        mul_ready;
    logic [15:0] mul_rd;
    logic [15:0] m_co;
    logic [2:0]  mul_rd_addr;
    logic        alu_valid;
    logic        alu_ready;
    logic [15:0] alu_rd;
    logic [2:0]  alu_rd_addr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        hi_we;
    logic [15:0] hi_wdata;
    logic [7:0]  pending_mask;

    mul_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mul_valid    (mul_valid),
        .mul_ready    (mul_ready),
        .mul_rd       (mul_rd),
        .m_co         (m_co),
        .mul_rd_addr  (mul_rd_addr),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_rd_addr  (alu_rd_addr),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .hi_we        (hi_we),
        .hi_wdata     (hi_wdata),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] co;
        logic [2:0]  a;
    } ent_t;

    ent_t        q[$];
    int          starve;
    int          total = 0;
    int          bad   = 0;
    logic        e_we;
    logic [2:0]  e_waddr;
    logic [15:0] e_wdata;
    logic        e_hwe;
    logic [15:0] e_hwdata;
    logic        last_ready;
    logic        last_alu;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic mv, input logic [15:0] rd,
                        input logic [15:0] co, input logic [2:0] ma,
                        input logic av, input logic [15:0] ar,
                        input logic [2:0] aa, input logic rn);
        logic       x_ready;
        logic       mg;
        logic       ag;
        logic [7:0] m;
        ent_t       h;
        bit         was_empty;
        mul_valid   = mv;
        mul_rd      = rd;
        m_co        = co;
        mul_rd_addr = ma;
        alu_valid   = av;
        alu_rd      = ar;
        alu_rd_addr = aa;
        rst_n       = rn;
        #1;
        x_ready = (q.size() < D);
        mg = (q.size() != 0) && (!av || q.size() == D || starve == SM);
        ag = av && !mg;
        m  = '0;
        foreach (q[i]) m[q[i].a] = 1'b1;
        m[0] = 1'b0;
        chk("mul_ready", mul_ready, x_ready);
        chk("alu_ready", alu_ready, ag);
        chk("pending_mask", pending_mask, m);
        last_ready = x_ready;
        last_alu   = ag;
        if (!rn) begin
            q.delete();
            starve   = 0;
            e_we     = 0;
            e_waddr  = 0;
            e_wdata  = 0;
            e_hwe    = 0;
            e_hwdata = 0;
        end else begin
            was_empty = (q.size() == 0);
            if (mg) begin
                h        = q.pop_front();
                e_we     = (h.a != 0);
                e_waddr  = h.a;
                e_wdata  = h.rd;
                e_hwe    = 1;
                e_hwdata = h.co;
            end else if (ag) begin
                e_we    = (aa != 0);
                e_waddr = aa;
                e_wdata = ar;
                e_hwe   = 0;
            end else begin
                e_we  = 0;
                e_hwe = 0;
            end
            if (was_empty || mg) starve = 0;
            else if (ag && starve < SM) starve++;
            if (mv && x_ready) q.push_back('{rd: rd, co: co, a: ma});
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, e_waddr);
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("hi_we", hi_we, e_hwe);
        chk("hi_wdata", hi_wdata, e_hwdata);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          n;
        int          j;
        logic [2:0]  t3a[3];
        logic [2:0]  seen[$];
        rst_n       = 0;
        mul_valid   = 0;
        mul_rd      = 0;
        m_co        = 0;
        mul_rd_addr = 0;
        alu_valid   = 0;
        alu_rd      = 0;
        alu_rd_addr = 0;
        starve      = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_hi_we", hi_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_hi_wdata", hi_wdata, 0);
        chk("rst_ready", mul_ready, 1);
        chk("rst_mask", pending_mask, 0);
        e_we = 0; e_waddr = 0; e_wdata = 0; e_hwe = 0; e_hwdata = 0;

        step(1, 16'h1234, 16'h0001, 3, 0, 0, 0, 1);
        chk("t1_mask", pending_mask, 8'h08);
        idle();
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 3);
        chk("t1_wdata", rf_wdata, 16'h1234);
        chk("t1_hi_we", hi_we, 1);
        chk("t1_hi_wdata", hi_wdata, 16'h0001);
        idle();

        step(1, 16'h5555, 16'h0AAA, 5, 1, 16'h1111, 2, 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 1, 16'($urandom), 3'($urandom), 1);
            if (last_alu) n++;
            else break;
        end
        chk("t2_alu_grants", n, 4);
        chk("t2_forced_hi", hi_we, 1);
        idle();

        t3a[0] = 1; t3a[1] = 2; t3a[2] = 4;
        j = 0;
        for (int k = 0; k < 30 && seen.size() < 3; k++) begin
            step(j < 3, 16'($urandom), 16'($urandom), (j < 3) ? t3a[j] : 3'd0,
                 1, 16'($urandom), 3'd6, 1);
            if (j < 3 && last_ready) j++;
            if (hi_we) seen.push_back(rf_waddr);
        end
        chk("t3_count", seen.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("t3_order", (k < seen.size()) ? seen[k] : 3'd7, t3a[k]);
        end
        idle();

        step(1, 16'hBEEF, 16'h00FF, 0, 0, 0, 0, 1);
        idle();
        chk("t4_we", rf_we, 0);
        chk("t4_hi_we", hi_we, 1);
        chk("t4_hi_wdata", hi_wdata, 16'h00FF);

        step(1, 16'h6666, 16'h0006, 6, 1, 16'h2222, 1, 1);
        step(1, 16'h7777, 16'h0007, 7, 1, 16'h3333, 1, 1);
        chk("t5_full", mul_ready, 0);
        step(1, 16'h8888, 16'h0008, 5, 1, 16'h4444, 1, 0);
        chk("t5_ready", mul_ready, 1);
        chk("t5_mask", pending_mask, 0);
        chk("t5_we", rf_we, 0);
        chk("t5_hi_we", hi_we, 0);
        repeat (3) idle();

        for (int k = 0; k < 8; k++) begin
            step(1, 16'($urandom), 16'($urandom), 3'($urandom_range(1, 7)),
                 0, 0, 0, 1);
        end
        repeat (3) idle();

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 2) != 0, 16'($urandom), 16'($urandom),
                 3'($urandom), $urandom_range(0, 3) != 0, 16'($urandom),
                 3'($urandom), $urandom_range(0, 49) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
